uart_rx_fsm: RTL
================

Name: uart_rx_fsm

Overview:
- Frame sequencer for the UART receive path.
- Detects a start condition on the serial line, then runs the per-bit oversampling edge counter (8 clocks per bit) and a bit counter.
- Drives the enables of the data sampler, the deserializer and the start/parity/stop checkers.
- Qualifies the assembled byte with a one-cycle data_valid pulse.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, LSB first.

Ports:
CLK  input  1  single clock for the block.
RST  input  1  synchronous, active-high reset.
RX_IN  input  1  serial line; idle high.
PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
strt_glitch  input  1  start checker result; valid in cycles where strt_chk_en=1.
par_err  input  1  parity checker result; valid in cycles where par_chk_en=1.
stp_err  input  1  stop checker result; valid in cycles where stp_chk_en=1.
edge_cnt  output  3  oversampling edge counter; a bit ends when edge_cnt==7.
bit_cnt  output  4  index of the current data bit, 0..DATA_WIDTH-1.
dat_samp_en  output  1  sampler enable.
deser_en  output  1  deserializer shift qualifier.
strt_chk_en  output  1  start checker strobe.
par_chk_en  output  1  parity checker strobe.
stp_chk_en  output  1  stop checker strobe.
data_valid  output  1  one-cycle pulse; the deserializer's parallel output holds a good byte.

Behaviour:
- Reset:
  - Sampled on the rising CLK edge while RST=1.
  - Next-state is IDLE; edge_cnt=0, bit_cnt=0, data_valid=0, internal par_err_l=0, par_en_l=0.
  - Reset has priority over every other event, including mid-frame. A frame in progress is abandoned with no data_valid.
- States: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - edge_cnt is registered; 0 in IDLE; in every non-IDLE state it increments each cycle and wraps 7->0.
  - bit_cnt is registered; cleared on entry to DATA; increments at edge_cnt==7 in DATA.
- IDLE:
  - All enables are 0.
  - RX_IN==0 sampled in IDLE -> START next cycle with edge_cnt=0.
- START:
  - dat_samp_en=1.
  - strt_chk_en=1 only in the cycle with edge_cnt==7.
  - At edge_cnt==7: if strt_glitch=1 -> IDLE; else -> DATA.
  - par_en_l<=PAR_EN is captured on the START->DATA transition only. PAR_EN changes mid-frame are ignored.
- DATA:
  - dat_samp_en=1 and deser_en=1 for the whole state. The deserializer shifts when deser_en=1 and edge_cnt==7, giving exactly DATA_WIDTH shifts per frame.
  - At edge_cnt==7 with bit_cnt==DATA_WIDTH-1: go to PARITY if par_en_l=1, else STOP. bit_cnt holds its final value.
- PARITY:
  - dat_samp_en=1.
  - par_chk_en=1 at edge_cnt==7.
  - At edge_cnt==7, par_err_l<=par_err, then -> STOP.
- STOP:
  - dat_samp_en=1.
  - stp_chk_en=1 at edge_cnt==7.
  - At edge_cnt==7: -> IDLE.
  - data_valid is registered: it is 1 in the following cycle iff stp_err==0 and par_err_l==0.
  - par_err_l is cleared on the same edge.
- data_valid:
  - High for exactly one cycle, coinciding with the first IDLE cycle.
  - The deserializer output is stable during that cycle because deser_en=0.
- Enable decoding:
  - Strobes (*_chk_en) are combinational from state and edge_cnt==7.
  - dat_samp_en and deser_en are decoded from state only.
- Back-to-back frames:
  - RX_IN==0 in the IDLE cycle right after STOP (the same cycle as data_valid) starts the next frame.
  - No mandatory idle gap beyond that one cycle.
- Line glitch: RX_IN returning high during START does not abort the frame early; rejection happens only via strt_glitch at edge_cnt==7.
- Frame timing, counted from the cycle RX_IN low is seen in IDLE (cycle 0), for DATA_WIDTH=8:
  - START occupies cycles 1-8.
  - DATA occupies cycles 9-72.
  - Without parity: STOP occupies cycles 73-80 and data_valid is high in cycle 81.
  - With parity: PARITY occupies 73-80, STOP 81-88, and data_valid is high in cycle 89.

Test Plan:
1. PAR_EN=0; send 0xA5, LSB first, 8 clocks per bit, checkers returning 0 -> deser_en high for cycles 9-72; 8 shift strobes (deser_en with edge_cnt==7); data_valid=1 only in cycle 81; deserializer output=0xA5.
2. PAR_EN=1; send 0x3C with par_err=0, then repeat with par_err=1 at par_chk_en -> first frame: data_valid in cycle 89. Second frame: no data_valid; FSM in IDLE at cycle 89.
3. RX_IN low for 2 cycles, then high, with strt_glitch=1 at cycle 8 -> returns to IDLE in cycle 9; deser_en never asserted; data_valid stays 0.
4. stp_err=1 at the stop strobe -> no data_valid; IDLE next cycle; a following good frame (0x5A) is received normally.
5. Two back-to-back frames (0x01, 0xFF), second start bit driven in cycle 81 -> data_valid in cycles 81 and 162; the second byte reads 0xFF.
6. RST=1 for one cycle at cycle 40 (mid-DATA) -> next cycle shows IDLE, edge_cnt=0, bit_cnt=0, all enables 0; no data_valid. PAR_EN toggled mid-frame in a separate frame has no effect on the state sequence.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: start detection, 8x oversampling edge/bit
// counters, sampler/deserializer/checker enables and the data_valid pulse.
module uart_rx_fsm #(
   parameter int DATA_WIDTH = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic       PAR_EN,
   input  logic       strt_glitch,
   input  logic       par_err,
   input  logic       stp_err,
   output logic [2:0] edge_cnt,
   output logic [3:0] bit_cnt,
   output logic       dat_samp_en,
   output logic       deser_en,
   output logic       strt_chk_en,
   output logic       par_chk_en,
   output logic       stp_chk_en,
   output logic       data_valid
);

   localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] edge_q, edge_d;
   logic [3:0] bit_q, bit_d;
   logic       valid_q, valid_d;
   logic       par_err_l_q, par_err_l_d;
   logic       par_en_l_q, par_en_l_d;
   logic       bit_end;

   assign bit_end = (edge_q == 3'd7);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         edge_q      <= 3'd0;
         bit_q       <= 4'd0;
         valid_q     <= 1'b0;
         par_err_l_q <= 1'b0;
         par_en_l_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         edge_q      <= edge_d;
         bit_q       <= bit_d;
         valid_q     <= valid_d;
         par_err_l_q <= par_err_l_d;
         par_en_l_q  <= par_en_l_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      edge_d      = (state_q == IDLE) ? 3'd0 : edge_q + 3'd1;
      bit_d       = bit_q;
      valid_d     = 1'b0;
      par_err_l_d = par_err_l_q;
      par_en_l_d  = par_en_l_q;
      dat_samp_en = 1'b0;
      deser_en    = 1'b0;
      strt_chk_en = 1'b0;
      par_chk_en  = 1'b0;
      stp_chk_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!RX_IN) state_d = START;
         end
         START: begin
            dat_samp_en = 1'b1;
            strt_chk_en = bit_end;
            if (bit_end) begin
               if (strt_glitch) begin
                  state_d = IDLE;
               end else begin
                  state_d    = DATA;
                  bit_d      = 4'd0;
                  par_en_l_d = PAR_EN;
               end
            end
         end
         DATA: begin
            dat_samp_en = 1'b1;
            deser_en    = 1'b1;
            if (bit_end) begin
               // bit_cnt parks on the last index once the byte is complete
               if (bit_q == LAST_BIT) begin
                  state_d = par_en_l_q ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         PARITY: begin
            dat_samp_en = 1'b1;
            par_chk_en  = bit_end;
            if (bit_end) begin
               par_err_l_d = par_err;
               state_d     = STOP;
            end
         end
         STOP: begin
            dat_samp_en = 1'b1;
            stp_chk_en  = bit_end;
            if (bit_end) begin
               valid_d     = !stp_err && !par_err_l_q;
               par_err_l_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign edge_cnt   = edge_q;
   assign bit_cnt    = bit_q;
   assign data_valid = valid_q;

endmodule
